// File: rtl/bch_decode_sched_pkg.sv
// Shared BCH scheduler types, parameter vector and sizing helpers.
// Pure definitions: no latency, no flow control.
package bch_decode_sched_pkg;

   typedef struct packed {
      int unsigned code_bits;
      int unsigned t;
   } bch_params_t;

   // BCH(15,5): 15 code bits, corrects up to 3 errors.
   localparam bch_params_t BCH_SANE = '{code_bits: 15, t: 3};

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_FEED = 1'b1
   } sched_state_e;

   function automatic int bch_code_bits(input bch_params_t p);
      return int'(p.code_bits);
   endfunction

   function automatic int bch_err_sz(input bch_params_t p);
      int sz;
      sz = $clog2(int'(p.t) + 1);
      return (sz < 1) ? 1 : sz;
   endfunction

   function automatic int bch_sched_beats(input bch_params_t p, input int bits);
      return (bch_code_bits(p) + bits - 1) / bits;
   endfunction

   function automatic int unsigned popcount(input logic [63:0] v);
      int unsigned c;
      c = 0;
      for (int i = 0; i < 64; i++) c += {31'd0, v[i]};
      return c;
   endfunction

endpackage

// File: rtl/bch_tag_fifo.sv
// Tag FIFO holding frames between input acceptance and syndrome hand-off.
// Pop data is the head, readable same cycle; push ignored when full, pop ignored when empty.
module bch_tag_fifo #(
   parameter int W     = 4,
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       push,
   input  logic [W-1:0]               push_dat,
   input  logic                       pop,
   output logic [W-1:0]               pop_dat,
   output logic [$clog2(DEPTH):0]     count,
   output logic                       full,
   output logic                       empty
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic          do_push, do_pop;

   assign full    = (count == CW'(DEPTH));
   assign empty   = (count == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign pop_dat = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= push_dat;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({do_push, do_pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/bch_decode_sched.sv
// Steers one codeword at a time through syndrome, key solver and error locator, carrying its tag.
// Stage handshakes are combinational; the completion record is registered one cycle after the err burst ends.
module bch_decode_sched
   import bch_decode_sched_pkg::*;
#(
   parameter bch_params_t P     = BCH_SANE,
   parameter int          BITS  = 1,
   parameter int          TAG_W = 4,
   parameter int          DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       in_start,
   input  logic [TAG_W-1:0]           in_tag,
   output logic                       in_ready,
   output logic                       syn_start,
   input  logic                       syn_busy,
   input  logic                       syn_done,
   output logic                       syn_accepted,
   output logic                       key_start,
   input  logic                       key_busy,
   input  logic                       key_done,
   input  logic [bch_err_sz(P)-1:0]   key_err_count,
   output logic                       key_accepted,
   output logic                       err_start,
   input  logic                       err_busy,
   input  logic                       err_valid,
   input  logic [BITS-1:0]            err,
   output logic                       out_valid,
   output logic [TAG_W-1:0]           out_tag,
   output logic [bch_err_sz(P)-1:0]   out_err_count,
   output logic                       out_fail,
   output logic                       fault
);
   localparam int          ERR_SZ  = bch_err_sz(P);
   localparam int          BEATS   = bch_sched_beats(P, BITS);
   localparam int          BCW     = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam int          CW      = $clog2(DEPTH) + 1;
   localparam int unsigned ERR_MAX = (32'd1 << ERR_SZ) - 32'd1;

   sched_state_e      state, state_nxt;
   logic [BCW-1:0]    beat_cnt;
   logic              rst_done;
   logic              fifo_push, fifo_full, fifo_empty;
   logic [TAG_W-1:0]  fifo_head;
   logic [CW-1:0]     fifo_count;

   logic              key_active, err_active, last_err_valid;
   logic [TAG_W-1:0]  key_tag, err_tag;
   logic [ERR_SZ-1:0] exp_cnt, found, found_sum;
   int unsigned       sum;
   logic              frame_end, fault_evt;

   bch_tag_fifo #(.W(TAG_W), .DEPTH(DEPTH)) u_tag_fifo (
      .clk      (clk),
      .reset    (reset),
      .push     (fifo_push),
      .push_dat (in_tag),
      .pop      (syn_accepted),
      .pop_dat  (fifo_head),
      .count    (fifo_count),
      .full     (fifo_full),
      .empty    (fifo_empty)
   );

   fifo_level_ok: assert property (@(posedge clk) disable iff (!reset)
      fifo_full == (fifo_count == CW'(DEPTH)));

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= ST_IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: if (syn_start && BEATS > 1) state_nxt = ST_FEED;
         ST_FEED: if (beat_cnt == BCW'(BEATS - 1)) state_nxt = ST_IDLE;
         default: state_nxt = ST_IDLE;
      endcase
   end

   // rst_done keeps in_ready low until the first edge after reset release.
   always_comb begin
      in_ready  = 1'b0;
      syn_start = 1'b0;
      fifo_push = 1'b0;
      if (state == ST_IDLE) begin
         in_ready  = rst_done && !syn_busy && (fifo_count < CW'(DEPTH));
         syn_start = in_start && in_ready;
         fifo_push = syn_start;
      end
   end

   assign syn_accepted = syn_done && !key_busy;
   assign key_start    = syn_accepted;
   assign key_accepted = !err_busy;
   assign err_start    = key_done && !err_busy && key_active;
   assign frame_end    = last_err_valid && !err_valid;
   assign fault_evt    = (syn_accepted && fifo_empty) || (key_done && !key_active)
                      || (in_start && state == ST_FEED);

   always_comb begin
      sum       = 32'(found) + popcount(64'(err));
      found_sum = (sum > ERR_MAX) ? ERR_SZ'(ERR_MAX) : ERR_SZ'(sum);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         beat_cnt       <= '0;
         rst_done       <= 1'b0;
         key_active     <= 1'b0;
         err_active     <= 1'b0;
         last_err_valid <= 1'b0;
         key_tag        <= '0;
         err_tag        <= '0;
         exp_cnt        <= '0;
         found          <= '0;
         out_valid      <= 1'b0;
         out_tag        <= '0;
         out_err_count  <= '0;
         out_fail       <= 1'b0;
         fault          <= 1'b0;
      end else begin
         rst_done       <= 1'b1;
         last_err_valid <= err_valid;
         out_valid      <= 1'b0;

         if (syn_start)             beat_cnt <= BCW'(1);
         else if (state == ST_FEED) beat_cnt <= beat_cnt + BCW'(1);

         if (err_valid && err_active) found <= found_sum;

         // A burst ending on the same cycle a new locator run starts is reported first.
         if (frame_end && err_active) begin
            out_valid     <= 1'b1;
            out_tag       <= err_tag;
            out_err_count <= found;
            out_fail      <= (found != exp_cnt);
            err_active    <= 1'b0;
         end

         if (err_start) begin
            err_tag    <= key_tag;
            exp_cnt    <= key_err_count;
            found      <= '0;
            err_active <= 1'b1;
            key_active <= 1'b0;
         end

         if (syn_accepted) begin
            key_tag    <= fifo_head;
            key_active <= 1'b1;
         end

         if (fault_evt) fault <= 1'b1;
      end
   end

endmodule

// File: tb/tb_bch_decode_sched.sv
// Directed bench for bch_decode_sched: the bench plays the three stages and checks every handshake and record.
// Configuration: BCH(15,5), BITS=1 -> 15 beats per frame, 2-bit error counts, 4-deep tag FIFO.
module tb_bch_decode_sched;
   import bch_decode_sched_pkg::*;

   localparam int BITS  = 1;
   localparam int TAG_W = 4;
   localparam int DEPTH = 4;

   logic             clk = 1'b0;
   logic             reset;
   logic             in_start, in_ready;
   logic [TAG_W-1:0] in_tag;
   logic             syn_start, syn_busy, syn_done, syn_accepted;
   logic             key_start, key_busy, key_done, key_accepted;
   logic [1:0]       key_err_count;
   logic             err_start, err_busy, err_valid;
   logic [BITS-1:0]  err;
   logic             out_valid;
   logic [TAG_W-1:0] out_tag;
   logic [1:0]       out_err_count;
   logic             out_fail, fault;

   int n_vec  = 0;
   int n_miss = 0;

   always #5 clk = ~clk;

   bch_decode_sched #(.P(BCH_SANE), .BITS(BITS), .TAG_W(TAG_W), .DEPTH(DEPTH)) dut (
      .clk           (clk),
      .reset         (reset),
      .in_start      (in_start),
      .in_tag        (in_tag),
      .in_ready      (in_ready),
      .syn_start     (syn_start),
      .syn_busy      (syn_busy),
      .syn_done      (syn_done),
      .syn_accepted  (syn_accepted),
      .key_start     (key_start),
      .key_busy      (key_busy),
      .key_done      (key_done),
      .key_err_count (key_err_count),
      .key_accepted  (key_accepted),
      .err_start     (err_start),
      .err_busy      (err_busy),
      .err_valid     (err_valid),
      .err           (err),
      .out_valid     (out_valid),
      .out_tag       (out_tag),
      .out_err_count (out_err_count),
      .out_fail      (out_fail),
      .fault         (fault)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_miss++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_reset();
      reset = 1'b0;
      #1;
      chk("rst_fault_clr", fault, 0);
      @(negedge clk);
      reset = 1'b1;
      tick();
   endtask

   task automatic wait_ready();
      for (int i = 0; i < 64 && !in_ready; i++) tick();
      chk("ready_wait", in_ready, 1);
   endtask

   // Accept one frame and walk through its 15 feed beats.
   task automatic start_frame(input logic [TAG_W-1:0] tag, input logic exp_ready);
      wait_ready();
      in_start = 1'b1;
      in_tag   = tag;
      #1 chk("syn_start", syn_start, 1);
      tick();
      in_start = 1'b0;
      repeat (13) tick();
      chk("ready_feed", in_ready, 0);
      tick();
      chk("ready_after", in_ready, exp_ready);
   endtask

   // Syndrome hand-off, key hand-off, error burst, then the completion record.
   task automatic finish_frame(input logic [TAG_W-1:0] tag, input logic [1:0] k,
                               input logic [14:0] pat, input int n,
                               input logic [1:0] exp_cnt, input logic exp_fail);
      syn_done = 1'b1;
      key_busy = 1'b0;
      #1;
      chk("syn_accepted", syn_accepted, 1);
      chk("key_start", key_start, 1);
      tick();
      syn_done      = 1'b0;
      key_done      = 1'b1;
      key_err_count = k;
      #1;
      chk("err_start", err_start, 1);
      chk("key_accepted", key_accepted, 1);
      tick();
      key_done = 1'b0;
      for (int i = 0; i < n; i++) begin
         err_valid = 1'b1;
         err       = pat[i];
         tick();
      end
      err_valid = 1'b0;
      err       = '0;
      #1 chk("out_early", out_valid, 0);
      tick();
      chk("out_valid", out_valid, 1);
      chk("out_tag", out_tag, tag);
      chk("out_cnt", out_err_count, exp_cnt);
      chk("out_fail", out_fail, exp_fail);
      tick();
      chk("out_pulse", out_valid, 0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      reset = 1'b0;
      in_start = 1'b1; in_tag = '0;
      syn_busy = 1'b0; syn_done = 1'b0;
      key_busy = 1'b0; key_done = 1'b0; key_err_count = '0;
      err_busy = 1'b0; err_valid = 1'b0; err = '0;

      // Reset state, with in_start held to prove nothing is accepted.
      repeat (2) @(negedge clk);
      chk("rst_in_ready", in_ready, 0);
      chk("rst_syn_start", syn_start, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_fault", fault, 0);
      in_start = 1'b0;
      reset    = 1'b1;
      #1 chk("ready_pre_edge", in_ready, 0);
      tick();
      chk("ready_post_edge", in_ready, 1);

      syn_busy = 1'b1;
      #1 chk("ready_syn_busy", in_ready, 0);
      syn_busy = 1'b0;
      #1 chk("ready_syn_idle", in_ready, 1);

      // Single frames: clean, 2 flips, uncorrectable, saturating count.
      start_frame(4'h3, 1'b1);
      finish_frame(4'h3, 2'd0, 15'h0000, 15, 2'd0, 1'b0);
      start_frame(4'h5, 1'b1);
      finish_frame(4'h5, 2'd2, 15'h0410, 15, 2'd2, 1'b0);
      start_frame(4'h9, 1'b1);
      finish_frame(4'h9, 2'd3, 15'h0100, 15, 2'd1, 1'b1);
      start_frame(4'hA, 1'b1);
      finish_frame(4'hA, 2'd3, 15'h001F, 15, 2'd3, 1'b0);
      chk("fault_single", fault, 0);

      // Fill the tag FIFO; in_ready must drop once DEPTH frames wait.
      start_frame(4'h1, 1'b1);
      start_frame(4'h2, 1'b1);
      start_frame(4'h3, 1'b1);
      start_frame(4'h4, 1'b0);
      syn_done = 1'b1;
      key_busy = 1'b1;
      #1 chk("syn_acc_keybusy", syn_accepted, 0);
      tick();
      syn_done = 1'b0;
      key_busy = 1'b0;
      finish_frame(4'h1, 2'd0, 15'h0000, 1, 2'd0, 1'b0);
      chk("ready_after_pop", in_ready, 1);
      for (int t = 2; t <= 4; t++)
         finish_frame(TAG_W'(t), 2'd1, 15'h0001, 1, 2'd1, 1'b0);
      chk("fault_b2b", fault, 0);

      // Reset while a second frame feeds and the first frame's err burst runs.
      start_frame(4'h6, 1'b1);
      syn_done = 1'b1;
      tick();
      syn_done      = 1'b0;
      key_done      = 1'b1;
      key_err_count = 2'd1;
      tick();
      key_done  = 1'b0;
      err_valid = 1'b1;
      err       = 1'b1;
      tick();
      tick();
      in_start = 1'b1;
      in_tag   = 4'h8;
      #1 chk("b_syn_start", syn_start, 1);
      tick();
      in_start = 1'b0;
      tick();
      reset = 1'b0;
      #1;
      chk("midrst_in_ready", in_ready, 0);
      chk("midrst_out_valid", out_valid, 0);
      chk("midrst_fault", fault, 0);
      @(negedge clk);
      reset = 1'b1;
      tick();
      chk("ready_post_rst", in_ready, 1);
      tick();
      err_valid = 1'b0;
      err       = '0;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("stale_drop", out_valid, 0);
      end
      chk("stale_fault", fault, 0);

      // syn_done with an empty FIFO: sticky fault.
      syn_done = 1'b1;
      #1 chk("empty_syn_acc", syn_accepted, 1);
      tick();
      syn_done = 1'b0;
      chk("fault_empty", fault, 1);
      repeat (3) tick();
      chk("fault_sticky", fault, 1);
      pulse_reset();

      // key_done with no frame in the key stage.
      key_done = 1'b1;
      #1 chk("stray_err_start", err_start, 0);
      tick();
      key_done = 1'b0;
      chk("fault_key", fault, 1);
      pulse_reset();

      // in_start while feeding.
      in_start = 1'b1;
      in_tag   = 4'h0;
      tick();
      tick();
      in_start = 1'b0;
      chk("fault_feed", fault, 1);
      pulse_reset();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
